// File: rtl/event_mux_pkg.sv
// event_mux_pkg: shared constants, FSM state type and round-robin search for event_mux41_rr.
package event_mux_pkg;
  localparam int NCH = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, OFFER} state_e;
  // Lowest offset from ptr (mod NCH) with a nonzero count wins.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NCH-1:0] nz, input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] sel;
    sel = ptr;
    for (int i = NCH - 1; i >= 0; i--)
      if (nz[ptr + SEL_W'(i)]) sel = ptr + SEL_W'(i);
    return sel;
  endfunction
endpackage

// File: rtl/event_mux41_rr_pend_cnt.sv
// pend_cnt: per-channel rising-edge detect, saturating pending counter and sticky overflow flag.
module pend_cnt #(
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic grant_i,
  input  logic ovf_clr,
  output logic nonzero,
  output logic ovf
);
  logic req_q, req_d, ovf_q, ovf_d, ev, sat;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    req_d = req_i;
    ev = req_i & ~req_q;
    sat = &cnt_q;
    cnt_d = (ev & ~grant_i & ~sat) ? cnt_q + 1'b1 : (grant_i & ~ev) ? cnt_q - 1'b1 : cnt_q;
    ovf_d = (ev & ~grant_i & sat) | (ovf_q & ~ovf_clr);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      req_q <= req_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  assign nonzero = |cnt_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/event_mux41_rr.sv
// event_mux41_rr: merges four event lines onto one valid/ready channel tagged with the source number.
module event_mux41_rr
  import event_mux_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [SEL_W-1:0] out_sel,
  output logic [NCH-1:0]   ovf,
  input  logic             ovf_clr
);
  state_e state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, sel_q, sel_d;
  logic [NCH-1:0] nz, grant;
  logic gnt;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pend_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk), .rst(rst), .req_i(req[i]), .grant_i(grant[i]),
      .ovf_clr(ovf_clr), .nonzero(nz[i]), .ovf(ovf[i])
    );
  end
  // Selection looks only at registered counts; a grant always forces one IDLE cycle.
  always_comb begin
    gnt = (state_q == OFFER) & out_ready;
    state_d = (state_q == IDLE) ? (|nz ? OFFER : IDLE) : (gnt ? IDLE : OFFER);
    sel_d = ((state_q == IDLE) & |nz) ? rr_pick(nz, ptr_q) : sel_q;
    ptr_d = gnt ? sel_q + 1'b1 : ptr_q;
    grant = gnt ? NCH'(1) << sel_q : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
    end
  assign out_valid = (state_q == OFFER);
  assign out_sel = sel_q;
endmodule
